// File: rtl/beep_pkg.sv
// Shared definitions for the piezo tone sequencer: FSM states, note half-period
// type, a sequence-length clamp helper and common 50 MHz half-period constants.
// No ports; imported by beep_tone_seq.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } beep_state_e;

  localparam int BEEP_DIV_W = 20;
  typedef logic [BEEP_DIV_W-1:0] note_hp_t;

  // Half-period minus one, in 50 MHz clocks.
  localparam note_hp_t HP_A4 = 20'd56_817;
  localparam note_hp_t HP_C5 = 20'd47_777;
  localparam note_hp_t HP_2K = 20'd12_499;
  localparam note_hp_t HP_3K = 20'd8_332;

  // Requested sequence length mapped into 1..n_notes.
  function automatic int clamp_len(input int raw, input int n_notes);
    if (raw == 0) return 1;
    if (raw > n_notes) return n_notes;
    return raw;
  endfunction

endpackage

// File: rtl/beep_tone_div.sv
// Square-wave divider for one note: counts 0..hp, toggles out at cnt==hp.
// Ports: clk, rst_n (async, active low), clr (restart at IDLE_LEVEL), hp (half-period
// minus 1, 0 = rest), out (registered square wave, IDLE_LEVEL while clr or hp==0).
module beep_tone_div #(
  parameter int   DIV_W      = 20,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] hp,
  output logic             out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (clr || hp == '0) begin
      cnt_d = '0;
      out_d = IDLE_LEVEL;
    end else if (cnt_q == hp) begin
      cnt_d = '0;
      out_d = ~out_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= IDLE_LEVEL;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/beep_tone_seq.sv
// Tone sequencer: plays up to N_NOTES table entries, DUR_CYCLES each, GAP_CYCLES of
// silence between, one-shot or looped. Ports: clk, rst_n, start/stop pulses, loop_en,
// seq_len, table write (tbl_we/addr/data); outputs beep_out, busy, done, note_idx.
module beep_tone_seq
  import beep_pkg::*;
#(
  parameter int   N_NOTES    = 8,
  parameter int   IDX_W      = 3,
  parameter int   DIV_W      = 20,
  parameter int   DUR_CYCLES = 12_500_000,
  parameter int   GAP_CYCLES = 1_250_000,
  parameter int   DUR_W      = 24,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [IDX_W:0]   seq_len,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic [DIV_W-1:0] tbl_data,
  output logic             beep_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx
);

  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  beep_state_e      state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [DIV_W-1:0] hp_q, hp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             advance, load_hp, last_note, div_clr;
  logic [DIV_W-1:0] tbl_q [N_NOTES];

  assign last_note = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hp_d    = hp_q;
    done_d  = 1'b0;
    advance = 1'b0;
    load_hp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_TONE;
          idx_d   = '0;
          len_d   = (IDX_W+1)'(clamp_len(int'(seq_len), N_NOTES));
          cnt_d   = '0;
          load_hp = 1'b1;
        end
      end
      ST_TONE: begin
        if (cnt_q == DUR_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) state_d = ST_GAP;
          else         advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (!last_note) begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_TONE;
        load_hp = 1'b1;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = ST_TONE;
        load_hp = 1'b1;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    // The half-period is captured once per note entry, so later table writes
    // never disturb the note already sounding.
    if (load_hp) hp_d = tbl_q[idx_d];

    if (stop) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = idx_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // The divider restarts at every note boundary and is held silent outside a
  // running tone, so each note begins at IDLE_LEVEL with a fresh count.
  assign div_clr = !(state_q == ST_TONE && cnt_q != DUR_LAST && !stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      hp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hp_q    <= hp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NOTES; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end

  beep_tone_div #(
    .DIV_W     (DIV_W),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .hp   (hp_q),
    .out  (beep_out)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_beep_tone_seq.sv
module tb_beep_tone_seq;

  localparam int N_NOTES = 4;
  localparam int IDX_W   = 2;
  localparam int DIV_W   = 8;
  localparam int DUR     = 100;
  localparam int GAP     = 10;
  localparam int PL      = DUR + GAP;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [IDX_W:0]   seq_len = '0;
  logic             tbl_we = 1'b0;
  logic [IDX_W-1:0] tbl_addr = '0;
  logic [DIV_W-1:0] tbl_data = '0;
  logic             beep_out, busy, done;
  logic [IDX_W-1:0] note_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int c;
    bit beep;
    bit bsy;
    bit dn;
    int idx;
    bit chk_idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   mtbl[N_NOTES];

  beep_tone_seq #(
    .N_NOTES   (N_NOTES),
    .IDX_W     (IDX_W),
    .DIV_W     (DIV_W),
    .DUR_CYCLES(DUR),
    .GAP_CYCLES(GAP),
    .DUR_W     (24),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .seq_len (seq_len),
    .tbl_we  (tbl_we),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .beep_out(beep_out),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // Monitor: compares every cycle for which an expectation was queued.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed expectation for cycle %0d", exp_q[0].c);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (beep_out !== e.beep || busy !== e.bsy || done !== e.dn ||
          (e.chk_idx && int'(note_idx) != e.idx)) begin
        errors++;
        $display("FAIL trace cyc=%0d got beep=%b busy=%b done=%b idx=%0d expected beep=%b busy=%b done=%b idx=%0d",
                 cyc, beep_out, busy, done, note_idx, e.beep, e.bsy, e.dn, e.idx);
      end
    end
  end

  task automatic push(input int c, input bit b, input bit bs, input bit d, input int idx, input bit ci);
    exp_t x;
    x.c = c; x.beep = b; x.bsy = bs; x.dn = d; x.idx = idx; x.chk_idx = ci;
    exp_q.push_back(x);
  endtask

  function automatic int clamp(input int r);
    return (r == 0) ? 1 : ((r > N_NOTES) ? N_NOTES : r);
  endfunction

  // Reference model: start in cycle P, note n of the playback occupies offsets
  // n*PL+1 .. (n+1)*PL (tone for the first DUR, silence after). Loop decision is
  // taken from loop_en in the last gap cycle of each pass.
  task automatic model(input int P, input int len, input bit loop0, input int loop_clr,
                       input int stop_off, input int wr_c, input int wr_a, input int wr_v,
                       output int span);
    int  end_off, n, w, note, hp, k_last;
    bit  stopped, b;
    end_off = 0;
    for (int j = 1; j <= 20 && end_off == 0; j++)
      if (!(loop0 && (P + j*len*PL) < loop_clr)) end_off = j*len*PL + 1;
    if (end_off == 0) end_off = 20*len*PL + 1;
    stopped = (stop_off > 0 && stop_off < end_off);
    k_last  = stopped ? stop_off + 4 : end_off + 3;
    for (int k = 1; k <= k_last; k++) begin
      if (stopped && k > stop_off) begin
        push(P+k, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      end else if (k < end_off) begin
        n    = (k-1) / PL;
        w    = (k-1) % PL;
        note = n % len;
        hp   = (wr_c >= 0 && wr_a == note && wr_c < P + n*PL) ? wr_v : mtbl[note];
        b    = (w >= DUR || hp == 0) ? 1'b1 : (((w / (hp+1)) % 2) == 0);
        push(P+k, b, 1'b1, 1'b0, note, 1'b1);
      end else begin
        push(P+k, 1'b1, 1'b0, (k == end_off), 0, 1'b0);
      end
    end
    span = k_last;
  endtask

  task automatic wr(input int a, input int v);
    @(posedge clk); #1;
    tbl_we = 1'b1; tbl_addr = IDX_W'(a); tbl_data = DIV_W'(v);
    @(posedge clk); #1;
    tbl_we = 1'b0;
    mtbl[a] = v;
  endtask

  // Offsets are relative to the start cycle; 0 means "not used".
  task automatic scenario(input int raw_len, input bit loop0, input int loop_off,
                          input int stop_off, input int wr_off, input int wr_a, input int wr_v,
                          input int xs_off, input int xs_len);
    int P, span;
    @(posedge clk); #1;
    P = cyc;
    model(P, clamp(raw_len), loop0, (loop_off > 0) ? P + loop_off : 0, stop_off,
          (wr_off > 0) ? P + wr_off : -1, wr_a, wr_v, span);
    start = 1'b1; seq_len = (IDX_W+1)'(raw_len); loop_en = loop0;
    for (int k = 1; k <= span; k++) begin
      @(posedge clk); #1;
      start   = (k == xs_off);
      if (k == xs_off) seq_len = (IDX_W+1)'(xs_len);
      stop    = (k == stop_off);
      loop_en = loop0 && (k < loop_off);
      tbl_we  = (k == wr_off);
      tbl_addr = IDX_W'(wr_a);
      tbl_data = DIV_W'(wr_v);
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; tbl_we = 1'b0; loop_en = 1'b0;
    if (wr_off > 0 && wr_off <= span) mtbl[wr_a] = wr_v;
  endtask

  task automatic start_stop_same;
    int P;
    @(posedge clk); #1;
    P = cyc;
    for (int k = 1; k <= 20; k++) push(P+k, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    start = 1'b1; stop = 1'b1; seq_len = 3'd2;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (21) @(posedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_beep"}, int'(beep_out), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_idx"},  int'(note_idx), 0);
  endtask

  initial begin
    int rl, sp, wo, xo, lo;
    bit lp;
    for (int i = 0; i < N_NOTES; i++) mtbl[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_idle("post_reset");

    // Two-note one-shot
    wr(0, 4); wr(1, 9);
    scenario(2, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    // Rest note
    wr(0, 0);
    scenario(1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    // Looped single note, loop cleared during the third pass
    wr(0, 3);
    scenario(1, 1'b1, 250, 0, 0, 0, 0, 0, 0);
    // Stop during a tone and during a gap, then start+stop together
    wr(0, 4);
    scenario(2, 1'b0, 0, 50, 0, 0, 0, 0, 0);
    scenario(2, 1'b0, 0, 105, 0, 0, 0, 0, 0);
    start_stop_same();
    // Start while busy with another length, zero length, oversize length
    scenario(2, 1'b0, 0, 0, 0, 0, 0, 30, 1);
    scenario(0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    wr(2, 2); wr(3, 7);
    scenario(7, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    // Table write to the playing note takes effect on the next pass
    scenario(1, 1'b1, 150, 0, 40, 0, 6, 0, 0);

    // Async reset in the middle of a cycle during playback clears everything
    @(posedge clk); #1;
    start = 1'b1; seq_len = 3'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    for (int i = 0; i < N_NOTES; i++) mtbl[i] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    scenario(4, 1'b0, 0, 0, 0, 0, 0, 0, 0);

    // Randomised playbacks
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < N_NOTES; a++)
        wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)));
      rl = $urandom_range(0, 7);
      lp = ($urandom_range(0, 2) == 0);
      lo = $urandom_range(1, 2 * clamp(rl) * PL);
      sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, clamp(rl) * PL)) : 0;
      wo = $urandom_range(1, 300);
      xo = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 90)) : 0;
      if (sp > 0 && sp <= xo) xo = 0;
      scenario(rl, lp, lo, sp, wo, $urandom_range(0, N_NOTES-1), $urandom_range(0, 20),
               xo, $urandom_range(0, 7));
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
